// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl -- memory-stage sequencer for the 8-bit nRisc datapath.
//   Purpose : takes one load/store at a time from execute (valid/ready), drives
//             the data memory bank strobes for one cycle, waits MEM_LATENCY
//             cycles for load data and returns it to writeback as a 1-cycle pulse.
//   Latency : store occupies 2 cycles (accept + ACCESS); load returns wb_valid in
//             cycle 2+MEM_LATENCY after the accept edge, ready again one cycle later.
//   Backpressure: req_ready is high only in IDLE; requests presented while busy
//             are ignored until the block returns to IDLE.
//
// Ports:
//   clock, reset                        rising-edge clock, async active-high reset
//   req_valid/req_ready                 request handshake from execute stage
//   req_write/req_addr/req_wdata/req_rd request fields (captured on accept)
//   mem_read/mem_write/mem_addr/mem_wdata/mem_rdata   data memory bank port
//   wb_valid/wb_rd/wb_data              load result pulse to writeback
//   busy                                high whenever not IDLE
//
// Optional feature macro: MEM_STAGE_BYPASS_EN
//   When defined, a one-entry record of the most recent store (address, data)
//   lets a load to the same address complete from the record without touching
//   the memory bank (IDLE -> RESP directly).

module mem_stage_ctrl #(
  parameter int MEM_LATENCY = 1,
  parameter int REG_W       = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [7:0]       req_addr,
  input  logic [7:0]       req_wdata,
  input  logic [REG_W-1:0] req_rd,
  output logic             mem_read,
  output logic             mem_write,
  output logic [7:0]       mem_addr,
  output logic [7:0]       mem_wdata,
  input  logic [7:0]       mem_rdata,
  output logic             wb_valid,
  output logic [REG_W-1:0] wb_rd,
  output logic [7:0]       wb_data,
  output logic             busy
);

  // Elaboration-time guard on the latency range the 3-bit counter supports.
  if (MEM_LATENCY < 1 || MEM_LATENCY > 7) begin : g_bad_latency
    $error("mem_stage_ctrl: MEM_LATENCY must be in 1..7");
  end

  // Counter starts at MEM_LATENCY-1 so that the count-0 cycle is exactly the
  // cycle in which mem_rdata is valid (cycle 1+MEM_LATENCY after accept).
  localparam logic [2:0] LAT_INIT = 3'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t             state_q,   state_d;
  logic               write_q,   write_d;
  logic [7:0]         addr_q,    addr_d;
  logic [7:0]         wdata_q,   wdata_d;
  logic [REG_W-1:0]   rd_q,      rd_d;
  logic [2:0]         cnt_q,     cnt_d;
  logic [7:0]         wb_data_q, wb_data_d;
  logic [REG_W-1:0]   wb_rd_q,   wb_rd_d;

  logic accept;
  logic bypass_hit;

  assign accept = req_valid && (state_q == S_IDLE);

`ifdef MEM_STAGE_BYPASS_EN
  // Record of the last accepted store. Only reset clears it.
  logic       rec_vld_q,  rec_vld_d;
  logic [7:0] rec_addr_q, rec_addr_d;
  logic [7:0] rec_data_q, rec_data_d;

  assign bypass_hit = !req_write && rec_vld_q && (rec_addr_q == req_addr);

  always_comb begin
    rec_vld_d  = rec_vld_q;
    rec_addr_d = rec_addr_q;
    rec_data_d = rec_data_q;
    if (accept && req_write) begin
      rec_vld_d  = 1'b1;
      rec_addr_d = req_addr;
      rec_data_d = req_wdata;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rec_vld_q  <= 1'b0;
      rec_addr_q <= 8'h00;
      rec_data_q <= 8'h00;
    end else begin
      rec_vld_q  <= rec_vld_d;
      rec_addr_q <= rec_addr_d;
      rec_data_q <= rec_data_d;
    end
  end
`else
  assign bypass_hit = 1'b0;
`endif

  // Next-state and datapath register updates.
  always_comb begin
    state_d   = state_q;
    write_d   = write_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rd_d      = rd_q;
    cnt_d     = cnt_q;
    wb_data_d = wb_data_q;
    wb_rd_d   = wb_rd_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rd_d    = req_rd;
          if (bypass_hit) begin
`ifdef MEM_STAGE_BYPASS_EN
            // Load satisfied from the store record: result is ready in cycle 1.
            wb_data_d = rec_data_q;
`endif
            wb_rd_d   = req_rd;
            state_d   = S_RESP;
          end else begin
            state_d = S_ACCESS;
          end
        end
      end

      S_ACCESS: begin
        if (write_q) begin
          state_d = S_IDLE;
        end else begin
          cnt_d   = LAT_INIT;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (cnt_q == 3'd0) begin
          wb_data_d = mem_rdata;
          wb_rd_d   = rd_q;
          state_d   = S_RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      write_q   <= 1'b0;
      addr_q    <= 8'h00;
      wdata_q   <= 8'h00;
      rd_q      <= '0;
      cnt_q     <= 3'd0;
      wb_data_q <= 8'h00;
      wb_rd_q   <= '0;
    end else begin
      state_q   <= state_d;
      write_q   <= write_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rd_q      <= rd_d;
      cnt_q     <= cnt_d;
      wb_data_q <= wb_data_d;
      wb_rd_q   <= wb_rd_d;
    end
  end

  // Outputs decode from registered state only, so there is no combinational
  // path from req_valid to the memory strobes, and reset drops them at once.
  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign mem_read  = (state_q == S_ACCESS) && !write_q;
  assign mem_write = (state_q == S_ACCESS) &&  write_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign wb_valid  = (state_q == S_RESP);
  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;

endmodule
